muovi_posizione: RTL
====================

Name: muovi_posizione

Overview:
- Position controller that produces the X_POS/Y_POS anchor consumed by the rettangolo/cornicetta hit-test stage.
- Once per frame (optionally every DIV frames) it steps the anchor by a per-axis direction times a speed.
- Positions wrap modulo H and V, matching the wrap-around handling of the downstream hit-test.
- Direction comes from four raw push-buttons, synchronised and edge-detected inside the block.

Parameters:
H, 1280, horizontal active width; X_POS range 0..H-1
V, 1024, vertical active height; Y_POS range 0..V-1
X_INIT, 590, X_POS after reset (must be < H)
Y_INIT, 462, Y_POS after reset (must be < V)
DIV, 1, number of accepted FRAME_TICKs per position step (1..255)

Ports:
CLK  in  1  pixel/system clock
RST  in  1  asynchronous, active-high reset
FRAME_TICK  in  1  one-cycle pulse at start of vertical blanking, synchronous to CLK
PAUSA  in  1  synchronous level; when 1, ticks are ignored
VEL  in  4  step size in pixels per update, 0..15
BTN_SU  in  1  raw async button: move up
BTN_GIU  in  1  raw async button: move down
BTN_SX  in  1  raw async button: move left
BTN_DX  in  1  raw async button: move right
X_POS  out  11  registered anchor X
Y_POS  out  11  registered anchor Y
AGGIORNATO  out  1  one-cycle pulse when X_POS/Y_POS take a new step result

Behaviour:
- Reset (async, immediate): X_POS=X_INIT, Y_POS=Y_INIT, AGGIORNATO=0, dx=dy=0, divider count=0, FSM=ATTESA, synchroniser and edge flops=0.
- Buttons: each passes through a 2-flop synchroniser plus a previous-value flop; a press is a synced 0->1 edge.
- Horizontal direction register dx in {-1,0,+1}:
  - SX edge sets dx=-1; DX edge sets dx=+1.
  - Both edges in the same cycle set dx=0.
  - Holding a button has no further effect.
- Vertical register dy: same rules; SU gives -1, GIU gives +1.
- Direction edges are accepted in every FSM state. An edge in the CALCOLA cycle affects the next step, not the current one.
- Divider: an 8-bit counter counts FRAME_TICKs accepted in ATTESA with PAUSA=0. A step fires when the count reaches DIV-1; the counter then returns to 0.
- FSM states:
  - ATTESA: if FRAME_TICK=1, PAUSA=0 and the divider fires, go to CALCOLA. A tick that does not fire only advances the counter; the FSM stays in ATTESA.
  - CALCOLA (exactly 1 cycle): compute and register new X/Y from dx, dy and VEL sampled in this cycle. Go to AGGIORNA.
  - AGGIORNA (1 cycle): AGGIORNATO=1. Go to ATTESA.
  - FRAME_TICK seen in CALCOLA or AGGIORNA is dropped and does not advance the divider.
- Latency: tick accepted at cycle n. New X_POS/Y_POS are visible at n+2, with AGGIORNATO=1 at n+2 only.
- X_POS/Y_POS are stable at all other times.
- Arithmetic is done in 12 bits:
  - dx=+1: s=X+VEL; X_new = s>=H ? s-H : s.
  - dx=-1: X_new = X<VEL ? X+H-VEL : X-VEL.
  - dx=0: X unchanged.
  - Y uses the same rules with V.
  - Outputs are always within 0..H-1 and 0..V-1; no intermediate value ever reaches the outputs.
- VEL=0 or dx=dy=0: a step still occurs (positions unchanged) and AGGIORNATO still pulses.
- PAUSA=1 on a tick cycle: no state change, no pulse, divider holds. Direction edges are still captured.
- Reset during CALCOLA/AGGIORNA: outputs return to init immediately; no AGGIORNATO pulse is emitted afterwards.

Test Plan:
- Reset released, 3 ticks, no buttons -> X_POS=590, Y_POS=462 throughout; AGGIORNATO pulses exactly 2 cycles after each tick.
- Press BTN_DX (held 10 cycles), VEL=10, tick at n -> X_POS=600 at n+2 (590 before); Y_POS=462; second tick -> 610.
- BTN_DX, VEL=15, 46 ticks -> X_POS=1265 after tick 45, 0 after tick 46; never >=1280.
- BTN_SU, VEL=6, 78 ticks -> Y_POS=0 after tick 77, 1018 after tick 78.
- BTN_SX and BTN_DX edges in the same cycle after dx=+1 -> dx=0; tick leaves X_POS unchanged, AGGIORNATO still pulses.
- PAUSA=1 over 5 ticks -> no pulse, no movement; DIV=2 build: only every second unpaused tick moves.
- RST asserted one cycle after an accepted tick -> X_POS=590, Y_POS=462 at once, no AGGIORNATO.

Source files
------------

// File: rtl/muovi_posizione.sv
// muovi_posizione: frame-rate position controller for the rettangolo/cornicetta
// hit-test anchor. Four raw buttons set a per-axis direction; every DIV
// accepted frame ticks the anchor moves by direction*VEL, wrapping modulo H/V.
module muovi_posizione #(
  parameter int H      = 1280,
  parameter int V      = 1024,
  parameter int X_INIT = 590,
  parameter int Y_INIT = 462,
  parameter int DIV    = 1
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        FRAME_TICK,
  input  logic        PAUSA,
  input  logic [3:0]  VEL,
  input  logic        BTN_SU,
  input  logic        BTN_GIU,
  input  logic        BTN_SX,
  input  logic        BTN_DX,
  output logic [10:0] X_POS,
  output logic [10:0] Y_POS,
  output logic        AGGIORNATO
);

  localparam logic [1:0] ATTESA   = 2'd0;
  localparam logic [1:0] CALCOLA  = 2'd1;
  localparam logic [1:0] AGGIORNA = 2'd2;

  // Direction encoding: two's complement of -1/0/+1 in two bits.
  localparam logic [1:0] DIR_ZERO = 2'b00;
  localparam logic [1:0] DIR_POS  = 2'b01;
  localparam logic [1:0] DIR_NEG  = 2'b11;

  localparam logic [11:0] H12      = 12'(H);
  localparam logic [11:0] V12      = 12'(V);
  localparam logic [10:0] X_RST    = 11'(X_INIT);
  localparam logic [10:0] Y_RST    = 11'(Y_INIT);
  localparam logic [7:0]  DIV_LAST = 8'(DIV - 1);

  // Button bit order: [3]=SU, [2]=GIU, [1]=SX, [0]=DX.
  logic [3:0] btn_raw;
  logic [3:0] btn_sync1;
  logic [3:0] btn_sync2;
  logic [3:0] btn_prev;
  logic [3:0] btn_edge;

  logic [1:0]  dx;
  logic [1:0]  dy;
  logic [1:0]  state;
  logic [7:0]  div_cnt;

  logic [11:0] x_ext;
  logic [11:0] y_ext;
  logic [11:0] vel_ext;
  logic [11:0] x_sum;
  logic [11:0] y_sum;
  logic [10:0] x_new;
  logic [10:0] y_new;

  assign btn_raw  = {BTN_SU, BTN_GIU, BTN_SX, BTN_DX};
  assign btn_edge = btn_sync2 & ~btn_prev;

  // Two-flop synchroniser for the raw buttons plus a history flop for edge detection.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      btn_sync1 <= 4'b0;
      btn_sync2 <= 4'b0;
      btn_prev  <= 4'b0;
    end else begin
      btn_sync1 <= btn_raw;
      btn_sync2 <= btn_sync1;
      btn_prev  <= btn_sync2;
    end
  end

  // Direction registers: a fresh press picks the direction, opposing presses together stop the axis.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      dx <= DIR_ZERO;
      dy <= DIR_ZERO;
    end else begin
      if (btn_edge[1] && btn_edge[0])
        dx <= DIR_ZERO;
      else if (btn_edge[1])
        dx <= DIR_NEG;
      else if (btn_edge[0])
        dx <= DIR_POS;

      if (btn_edge[3] && btn_edge[2])
        dy <= DIR_ZERO;
      else if (btn_edge[3])
        dy <= DIR_NEG;
      else if (btn_edge[2])
        dy <= DIR_POS;
    end
  end

  assign x_ext   = {1'b0, X_POS};
  assign y_ext   = {1'b0, Y_POS};
  assign vel_ext = {8'b0, VEL};
  assign x_sum   = x_ext + vel_ext;
  assign y_sum   = y_ext + vel_ext;

  // Next anchor with modulo wrap; inputs are in range so a single correction suffices.
  always_comb begin
    x_new = X_POS;
    y_new = Y_POS;
    case (dx)
      DIR_POS: x_new = (x_sum >= H12) ? 11'(x_sum - H12) : x_sum[10:0];
      DIR_NEG: x_new = (x_ext < vel_ext) ? 11'(x_ext + H12 - vel_ext) : 11'(x_ext - vel_ext);
      default: x_new = X_POS;
    endcase
    case (dy)
      DIR_POS: y_new = (y_sum >= V12) ? 11'(y_sum - V12) : y_sum[10:0];
      DIR_NEG: y_new = (y_ext < vel_ext) ? 11'(y_ext + V12 - vel_ext) : 11'(y_ext - vel_ext);
      default: y_new = Y_POS;
    endcase
  end

  // Frame divider and step sequencer; ticks outside ATTESA or while paused are ignored.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state      <= ATTESA;
      div_cnt    <= 8'd0;
      X_POS      <= X_RST;
      Y_POS      <= Y_RST;
      AGGIORNATO <= 1'b0;
    end else begin
      AGGIORNATO <= 1'b0;
      case (state)
        ATTESA: begin
          if (FRAME_TICK && !PAUSA) begin
            if (div_cnt == DIV_LAST) begin
              div_cnt <= 8'd0;
              state   <= CALCOLA;
            end else begin
              div_cnt <= div_cnt + 8'd1;
            end
          end
        end
        CALCOLA: begin
          X_POS      <= x_new;
          Y_POS      <= y_new;
          AGGIORNATO <= 1'b1;
          state      <= AGGIORNA;
        end
        AGGIORNA: state <= ATTESA;
        default:  state <= ATTESA;
      endcase
    end
  end

endmodule
